// File: rtl/bp_be_issue_buffer_if.sv
// Issue-buffer handshake bundle: front-end fetch side, flush/dispatch
// control from the backend, and the head-of-buffer issue status.
// The buffer connects through the slave modport; the driver of fetch
// and dispatch (front end / checker) uses the master modport.
interface bp_be_issue_buffer_if #(
    parameter int depth_p       = 8,
    parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32
);
    localparam int count_width_lp = $clog2(depth_p) + 1;

    // Front-end fetch handshake
    logic                      fe_v_i;
    logic [vaddr_width_p-1:0]  fe_pc_i;
    logic [instr_width_p-1:0]  fe_instr_i;
    logic                      fe_ready_o;

    // Backend control
    logic                      flush_i;
    logic                      dispatch_i;

    // Head-of-buffer issue status
    logic                      issue_v_o;
    logic [vaddr_width_p-1:0]  issue_pc_o;
    logic [instr_width_p-1:0]  issue_instr_o;
    logic [4:0]                rs1_addr_o;
    logic [4:0]                rs2_addr_o;
    logic [4:0]                rs3_addr_o;
    logic [4:0]                rd_addr_o;
    logic                      irs1_v_o;
    logic                      irs2_v_o;
    logic                      frs1_v_o;
    logic                      frs2_v_o;
    logic                      frs3_v_o;
    logic                      iwb_v_o;
    logic                      fwb_v_o;
    logic                      mem_v_o;
    logic                      csr_v_o;
    logic                      fence_v_o;
    logic [count_width_lp-1:0] count_o;

    modport slave (
        input  fe_v_i, fe_pc_i, fe_instr_i, flush_i, dispatch_i,
        output fe_ready_o, issue_v_o, issue_pc_o, issue_instr_o,
               rs1_addr_o, rs2_addr_o, rs3_addr_o, rd_addr_o,
               irs1_v_o, irs2_v_o, frs1_v_o, frs2_v_o, frs3_v_o,
               iwb_v_o, fwb_v_o, mem_v_o, csr_v_o, fence_v_o, count_o
    );

    modport master (
        output fe_v_i, fe_pc_i, fe_instr_i, flush_i, dispatch_i,
        input  fe_ready_o, issue_v_o, issue_pc_o, issue_instr_o,
               rs1_addr_o, rs2_addr_o, rs3_addr_o, rd_addr_o,
               irs1_v_o, irs2_v_o, frs1_v_o, frs2_v_o, frs3_v_o,
               iwb_v_o, fwb_v_o, mem_v_o, csr_v_o, fence_v_o, count_o
    );
endinterface

// File: rtl/bp_be_issue_buffer.sv
// Instruction issue buffer between fetch and the backend hazard detector.
// Circular buffer of depth_p entries; each entry stores PC, instruction
// and the operand/writeback/class flags predecoded at enqueue time.
// The head entry is presented as issue status; dispatch pops it, flush
// drops everything.
// Optional feature: define BP_BE_ISSUE_BUFFER_BYPASS_EN to let an incoming
// instruction drive the head outputs in the same cycle when the buffer is
// empty (and be consumed without a write if dispatched that cycle).
module bp_be_issue_buffer #(
    parameter int depth_p       = 8,
    parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32
) (
    input logic                 clk_i,
    input logic                 reset_n_i,
    bp_be_issue_buffer_if.slave bus
);
    localparam int idx_w_lp = $clog2(depth_p);
    localparam int ptr_w_lp = idx_w_lp + 1;

    localparam logic [6:0] op_load_lp     = 7'b0000011;
    localparam logic [6:0] op_load_fp_lp  = 7'b0000111;
    localparam logic [6:0] op_misc_mem_lp = 7'b0001111;
    localparam logic [6:0] op_imm_lp      = 7'b0010011;
    localparam logic [6:0] op_auipc_lp    = 7'b0010111;
    localparam logic [6:0] op_imm_32_lp   = 7'b0011011;
    localparam logic [6:0] op_store_lp    = 7'b0100011;
    localparam logic [6:0] op_store_fp_lp = 7'b0100111;
    localparam logic [6:0] op_amo_lp      = 7'b0101111;
    localparam logic [6:0] op_op_lp       = 7'b0110011;
    localparam logic [6:0] op_lui_lp      = 7'b0110111;
    localparam logic [6:0] op_op_32_lp    = 7'b0111011;
    localparam logic [6:0] op_fmadd_lp    = 7'b1000011;
    localparam logic [6:0] op_fmsub_lp    = 7'b1000111;
    localparam logic [6:0] op_fnmsub_lp   = 7'b1001011;
    localparam logic [6:0] op_fnmadd_lp   = 7'b1001111;
    localparam logic [6:0] op_op_fp_lp    = 7'b1010011;
    localparam logic [6:0] op_branch_lp   = 7'b1100011;
    localparam logic [6:0] op_jalr_lp     = 7'b1100111;
    localparam logic [6:0] op_jal_lp      = 7'b1101111;
    localparam logic [6:0] op_system_lp   = 7'b1110011;

    typedef struct packed {
        logic irs1_v;
        logic irs2_v;
        logic frs1_v;
        logic frs2_v;
        logic frs3_v;
        logic iwb_v;
        logic fwb_v;
        logic mem_v;
        logic csr_v;
        logic fence_v;
    } predecode_s;

    // Opcode-driven predecode of operand sources, writeback target and class.
    function automatic predecode_s predecode(input logic [31:0] instr);
        predecode_s pd;
        logic [6:0] op;
        logic [2:0] f3;
        logic [4:0] f5;
        pd = '0;
        op = instr[6:0];
        f3 = instr[14:12];
        f5 = instr[31:27];
        case (op)
            op_op_lp, op_op_32_lp: begin
                pd.irs1_v = 1'b1; pd.irs2_v = 1'b1; pd.iwb_v = 1'b1;
            end
            op_imm_lp, op_imm_32_lp, op_jalr_lp: begin
                pd.irs1_v = 1'b1; pd.iwb_v = 1'b1;
            end
            op_load_lp: begin
                pd.irs1_v = 1'b1; pd.iwb_v = 1'b1; pd.mem_v = 1'b1;
            end
            op_store_lp: begin
                pd.irs1_v = 1'b1; pd.irs2_v = 1'b1; pd.mem_v = 1'b1;
            end
            op_branch_lp: begin
                pd.irs1_v = 1'b1; pd.irs2_v = 1'b1;
            end
            op_amo_lp: begin
                pd.irs1_v = 1'b1; pd.irs2_v = 1'b1;
                pd.iwb_v  = 1'b1; pd.mem_v  = 1'b1;
            end
            op_load_fp_lp: begin
                pd.irs1_v = 1'b1; pd.fwb_v = 1'b1; pd.mem_v = 1'b1;
            end
            op_store_fp_lp: begin
                pd.irs1_v = 1'b1; pd.frs2_v = 1'b1; pd.mem_v = 1'b1;
            end
            op_lui_lp, op_auipc_lp, op_jal_lp: begin
                pd.iwb_v = 1'b1;
            end
            op_fmadd_lp, op_fmsub_lp, op_fnmsub_lp, op_fnmadd_lp: begin
                pd.frs1_v = 1'b1; pd.frs2_v = 1'b1;
                pd.frs3_v = 1'b1; pd.fwb_v  = 1'b1;
            end
            op_op_fp_lp: begin
                case (f5)
                    // FCVT from int, FMV.W.X: integer source, FP result
                    5'b11010, 5'b11110: begin
                        pd.irs1_v = 1'b1; pd.fwb_v = 1'b1;
                    end
                    // FSQRT, FCVT between FP formats: single FP source
                    5'b01011, 5'b01000: begin
                        pd.frs1_v = 1'b1; pd.fwb_v = 1'b1;
                    end
                    // FCVT to int, FMV.X / FCLASS: single FP source, int result
                    5'b11000, 5'b11100: begin
                        pd.frs1_v = 1'b1; pd.iwb_v = 1'b1;
                    end
                    // Compares: two FP sources, int result
                    5'b10100: begin
                        pd.frs1_v = 1'b1; pd.frs2_v = 1'b1; pd.iwb_v = 1'b1;
                    end
                    default: begin
                        pd.frs1_v = 1'b1; pd.frs2_v = 1'b1; pd.fwb_v = 1'b1;
                    end
                endcase
            end
            op_system_lp: begin
                pd.csr_v  = 1'b1;
                pd.irs1_v = (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd3);
                pd.iwb_v  = (f3 != 3'd0);
            end
            op_misc_mem_lp: begin
                pd.fence_v = 1'b1;
            end
            default: pd = '0;
        endcase
        return pd;
    endfunction

    logic [ptr_w_lp-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ptr_w_lp-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ptr_w_lp-1:0] count_reg, count_next;

    logic [vaddr_width_p-1:0] pc_mem    [depth_p];
    logic [instr_width_p-1:0] instr_mem [depth_p];
    predecode_s               pd_mem    [depth_p];

    logic [idx_w_lp-1:0] wr_idx;
    logic [idx_w_lp-1:0] rd_idx;
    logic                empty;
    logic                full;
    logic                ready;
    logic                enq;
    logic                deq;
    logic                bypass_v;
    predecode_s          fe_pd;

    logic                     head_v;
    logic [vaddr_width_p-1:0] head_pc;
    logic [instr_width_p-1:0] head_instr;
    predecode_s               head_pd;

    assign wr_idx = wr_ptr_reg[idx_w_lp-1:0];
    assign rd_idx = rd_ptr_reg[idx_w_lp-1:0];
    assign empty  = (wr_ptr_reg == rd_ptr_reg);
    assign full   = (wr_idx == rd_idx) &&
                    (wr_ptr_reg[ptr_w_lp-1] != rd_ptr_reg[ptr_w_lp-1]);
    assign ready  = ~full & reset_n_i;
    assign fe_pd  = predecode(bus.fe_instr_i[31:0]);

`ifdef BP_BE_ISSUE_BUFFER_BYPASS_EN
    assign bypass_v = empty & bus.fe_v_i & ~bus.flush_i & reset_n_i;
`else
    assign bypass_v = 1'b0;
`endif

    // A bypassed instruction that is dispatched in the same cycle is never written.
    assign enq = bus.fe_v_i & ready & ~bus.flush_i & ~(bypass_v & bus.dispatch_i);
    // Only stored entries advance the read pointer; a bypass pop leaves it alone.
    assign deq = bus.dispatch_i & ~empty & ~bus.flush_i;

    // Pointer and occupancy registers; flush wins over enq/deq.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Next pointer/occupancy values from the enq/deq/flush events.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (bus.flush_i) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (enq) wr_ptr_next = wr_ptr_reg + ptr_w_lp'(1);
            if (deq) rd_ptr_next = rd_ptr_reg + ptr_w_lp'(1);
            case ({enq, deq})
                2'b10:   count_next = count_reg + ptr_w_lp'(1);
                2'b01:   count_next = count_reg - ptr_w_lp'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // Per-entry storage with one-hot write decode; contents need no reset
    // because head outputs are masked whenever the head is invalid.
    for (genvar gi = 0; gi < depth_p; gi++) begin : g_entry
        // Capture PC, instruction and predecode into this slot on enqueue.
        always_ff @(posedge clk_i) begin
            if (enq && (wr_idx == idx_w_lp'(gi))) begin
                pc_mem[gi]    <= bus.fe_pc_i;
                instr_mem[gi] <= bus.fe_instr_i;
                pd_mem[gi]    <= fe_pd;
            end
        end
    end

    // Select the head entry: storage, or the incoming instruction on bypass.
    always_comb begin
        head_v     = ~empty;
        head_pc    = pc_mem[rd_idx];
        head_instr = instr_mem[rd_idx];
        head_pd    = pd_mem[rd_idx];
`ifdef BP_BE_ISSUE_BUFFER_BYPASS_EN
        if (bypass_v) begin
            head_v     = 1'b1;
            head_pc    = bus.fe_pc_i;
            head_instr = bus.fe_instr_i;
            head_pd    = fe_pd;
        end
`endif
    end

    assign bus.fe_ready_o    = ready;
    assign bus.count_o       = count_reg;
    assign bus.issue_v_o     = head_v;
    assign bus.issue_pc_o    = {vaddr_width_p{head_v}} & head_pc;
    assign bus.issue_instr_o = {instr_width_p{head_v}} & head_instr;
    assign bus.rs1_addr_o    = {5{head_v}} & head_instr[19:15];
    assign bus.rs2_addr_o    = {5{head_v}} & head_instr[24:20];
    assign bus.rs3_addr_o    = {5{head_v}} & head_instr[31:27];
    assign bus.rd_addr_o     = {5{head_v}} & head_instr[11:7];
    assign bus.irs1_v_o      = head_v & head_pd.irs1_v;
    assign bus.irs2_v_o      = head_v & head_pd.irs2_v;
    assign bus.frs1_v_o      = head_v & head_pd.frs1_v;
    assign bus.frs2_v_o      = head_v & head_pd.frs2_v;
    assign bus.frs3_v_o      = head_v & head_pd.frs3_v;
    assign bus.iwb_v_o       = head_v & head_pd.iwb_v;
    assign bus.fwb_v_o       = head_v & head_pd.fwb_v;
    assign bus.mem_v_o       = head_v & head_pd.mem_v;
    assign bus.csr_v_o       = head_v & head_pd.csr_v;
    assign bus.fence_v_o     = head_v & head_pd.fence_v;

endmodule
